// File: rtl/fp_addsub_result_stage.sv
// Two-entry registered output stage for the single-precision add/sub unit: saturation/flush-to-zero at push,
// result classification, sticky exception flags and a completed-result counter. Latency 1 cycle into an empty buffer.
module fp_addsub_result_stage #(
    parameter int CNT_W  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_overflow,
    input  logic             in_underflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic             out_is_zero,
    output logic             out_is_inf,
    output logic             out_is_nan,
    input  logic             clear_flags,
    output logic             sticky_overflow,
    output logic             sticky_underflow,
    output logic             sticky_nan,
    output logic [CNT_W-1:0] result_count
);

    typedef struct packed {
        logic [31:0] result;
        logic        ovf;
        logic        unf;
        logic        is_zero;
        logic        is_inf;
        logic        is_nan;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    entry_t           r_head;
    entry_t           r_tail;
    logic             r_sticky_ovf;
    logic             r_sticky_unf;
    logic             r_sticky_nan;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_sign;
    logic [7:0]       w_exp;
    logic [31:0]      w_proc_result;
    entry_t           w_new;

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign w_sign = in_result[31];
    assign w_exp  = in_result[30:23];

    // Overflow takes priority over underflow; a zero exponent (subnormal) is flushed to signed zero.
    always_comb begin
        w_proc_result = in_result;
        if (SAT_EN) begin
            if (in_overflow) begin
                w_proc_result = {w_sign, 8'hFF, 23'h0};
            end else if (in_underflow || (w_exp == 8'h00)) begin
                w_proc_result = {w_sign, 31'h0};
            end
        end
    end

    always_comb begin
        w_new         = '0;
        w_new.result  = w_proc_result;
        w_new.ovf     = in_overflow;
        w_new.unf     = in_underflow;
        w_new.is_zero = (w_proc_result[30:0] == 31'h0);
        w_new.is_inf  = (w_proc_result[30:23] == 8'hFF) && (w_proc_result[22:0] == 23'h0);
        w_new.is_nan  = (w_proc_result[30:23] == 8'hFF) && (w_proc_result[22:0] != 23'h0);
    end

    // Head is always the oldest entry, so outputs come straight from r_head without a read mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_head  <= w_new;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= w_new;
                    end else if (w_push) begin
                        r_tail  <= w_new;
                        r_state <= ST_FULL;
                    end else if (w_pop) begin
                        r_state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_head  <= r_tail;
                        r_state <= ST_ONE;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // A clear coinciding with a push keeps the new event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky_ovf <= 1'b0;
            r_sticky_unf <= 1'b0;
            r_sticky_nan <= 1'b0;
        end else begin
            r_sticky_ovf <= (r_sticky_ovf & ~clear_flags) | (w_push & in_overflow);
            r_sticky_unf <= (r_sticky_unf & ~clear_flags) | (w_push & in_underflow);
            r_sticky_nan <= (r_sticky_nan & ~clear_flags) | (w_push & w_new.is_nan);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_pop) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign out_result       = r_head.result;
    assign out_overflow     = r_head.ovf;
    assign out_underflow    = r_head.unf;
    assign out_is_zero      = r_head.is_zero;
    assign out_is_inf       = r_head.is_inf;
    assign out_is_nan       = r_head.is_nan;
    assign sticky_overflow  = r_sticky_ovf;
    assign sticky_underflow = r_sticky_unf;
    assign sticky_nan       = r_sticky_nan;
    assign result_count     = r_count;

endmodule

// File: doc/fp_addsub_result_stage.md
Name: fp_addsub_result_stage

Overview:
- Registered output stage directly downstream of the combinational single-precision add/sub unit.
- Captures result/overflow/underflow through a valid/ready handshake into a 2-entry buffer.
- Applies IEEE754 special-value saturation and flush-to-zero; classifies each result.
- Maintains sticky exception flags and a completed-result counter for the FPU control logic.

Parameters:
CNT_W, 16, width of the completed-result counter.
SAT_EN, 1, 1 = replace overflow/underflow/subnormal results with ±inf/±0; 0 = pass in_result unmodified (classification still applied).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream result valid
in_ready  output  1  stage can accept a result this cycle
in_result  input  32  raw result from add/sub unit {sign, exp[7:0], frac[22:0]}
in_overflow  input  1  add/sub overflow
in_underflow  input  1  add/sub underflow
out_valid  output  1  buffered result available
out_ready  input  1  consumer accepts head entry
out_result  output  32  post-processed result
out_overflow  output  1  head entry overflowed
out_underflow  output  1  head entry underflowed
out_is_zero  output  1  out_result exp==0 and frac==0
out_is_inf  output  1  out_result exp==8'hFF and frac==0
out_is_nan  output  1  out_result exp==8'hFF and frac!=0
clear_flags  input  1  single-cycle clear of sticky flags
sticky_overflow  output  1  accumulated overflow
sticky_underflow  output  1  accumulated underflow
sticky_nan  output  1  accumulated NaN result
result_count  output  CNT_W  number of results popped, modulo 2^CNT_W

Behaviour:
- Reset: buffer empty, in_ready=1, out_valid=0, out_result=0, out_overflow=0, out_underflow=0, all out_is_*=0, sticky flags=0, result_count=0. Reset mid-operation discards buffered entries immediately.
- Push = in_valid & in_ready; pop = out_valid & out_ready. Occupancy states: EMPTY(0), ONE(1), FULL(2).
- Transitions:
  - EMPTY: push→ONE.
  - ONE: push&!pop→FULL; pop&!push→EMPTY; push&pop→ONE, new entry becomes head next cycle.
  - FULL: pop→ONE. No push is possible in FULL.
- in_ready = (state!=FULL), driven from registered state only; there is no combinational path from out_ready to in_ready.
- out_valid = (state!=EMPTY). Head entry outputs come directly from storage registers.
- Latency: an accepted entry appears at the outputs on the next clock edge when the buffer was empty.
- FIFO order is strictly preserved. The head holds stable while out_valid & !out_ready.
- Post-processing is applied at push time; the stored value is already processed. s = in_result[31].
  - SAT_EN=1, priority order:
    - in_overflow → {s,8'hFF,23'h0}.
    - else in_underflow → {s,31'h0}.
    - else in_result[30:23]==0 → {s,31'h0} (flush-to-zero).
    - else pass unchanged.
  - If overflow and underflow are both asserted, overflow wins for the result. Both flags are still stored and reported.
  - SAT_EN=0: result is passed through; flags are stored only.
- Classification is computed on the stored processed result.
- Sticky flags update on push only. Next value = (clear_flags ? 0 : current) | new event:
  - new overflow event = in_overflow.
  - new underflow event = in_underflow.
  - new NaN event = processed result is NaN.
  - A clear and a push in the same cycle therefore retain the new event.
- result_count increments by 1 on each pop and wraps from 2^CNT_W−1 to 0.

Test Plan:
- Reset, then push in_result=32'h3F800000 with no flags → next cycle out_valid=1, out_result=32'h3F800000, all out_is_*=0. Pop → result_count=1, out_valid=0.
- Push 32'h7F000000 with in_overflow=1 → out_result=32'h7F800000, out_is_inf=1, sticky_overflow=1. Push 32'h80000123 with in_underflow=1 → out_result=32'h80000000, out_is_zero=1.
- Hold out_ready=0 and offer three results (A,B,C) back-to-back → A and B accepted, in_ready=0 from the cycle after B, C held. Then raise out_ready → A, B, C emerge in order, with one push and one pop in the same cycle while state=ONE.
- Push 32'h7FC00000 with clear_flags=1 in the same cycle → sticky_nan=1, out_is_nan=1. A later isolated clear_flags → all sticky flags=0.
- With CNT_W=4, pop 17 results → result_count=1. Assert rst while FULL → out_valid=0, in_ready=1, flags=0, count=0 asynchronously.
- With SAT_EN=0, push 32'h00400000 → out_result=32'h00400000, out_is_zero=0.
